// File: rtl/sa_feeder.sv
// sa_feeder: skews A/B rows into a SIZE x SIZE systolic array edge.
// Ports: clk, rst_n; i_vld/o_rdy/i_row/i_is_b/i_last input row handshake;
//   o_we weight strobe; o_a_vld/o_a_rows skewed left-edge lanes;
//   o_c_vld result-valid seeds; o_busy (not IDLE); o_err protocol error.
// Option: define SA_FEEDER_STATS_EN to add o_row_cnt (forwarded A rows).
module sa_feeder #(
   parameter int WIDTH = 16,
   parameter int SIZE  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_vld,
   output logic                        o_rdy,
   input  logic [SIZE-1:0][WIDTH-1:0]  i_row,
   input  logic                        i_is_b,
   input  logic                        i_last,
   output logic                        o_we,
   output logic [SIZE-1:0]             o_a_vld,
   output logic [SIZE-1:0][WIDTH-1:0]  o_a_rows,
   output logic [SIZE-1:0]             o_c_vld,
   output logic                        o_busy,
   output logic                        o_err
`ifdef SA_FEEDER_STATS_EN
   ,
   output logic [15:0]                 o_row_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STREAM,
      DRAIN
   } state_t;

   localparam int CW = $clog2(SIZE);
   localparam logic [CW-1:0] LOAD_END  = CW'(SIZE - 1);
   localparam logic [CW-1:0] DRAIN_END = CW'(SIZE - 2);

   state_t        state, state_nx;
   logic          w_loaded, w_loaded_nx;
   // Shared: B-row count in LOAD, cycle count in DRAIN.
   logic [CW-1:0] cnt, cnt_nx;
   logic          acc, fwd_a, fwd_b, err;

   assign o_rdy  = (state != DRAIN);
   assign o_busy = (state != IDLE);
   assign acc    = i_vld & o_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         w_loaded <= 1'b0;
         cnt      <= '0;
         o_we     <= 1'b0;
         o_err    <= 1'b0;
      end else begin
         state    <= state_nx;
         w_loaded <= w_loaded_nx;
         cnt      <= cnt_nx;
         o_we     <= fwd_b;
         o_err    <= err;
      end
   end

   always_comb begin
      state_nx    = state;
      w_loaded_nx = w_loaded;
      cnt_nx      = cnt;
      fwd_a       = 1'b0;
      fwd_b       = 1'b0;
      err         = 1'b0;
      unique case (state)
         IDLE: begin
            if (acc) begin
               if (i_is_b) begin
                  fwd_b    = 1'b1;
                  cnt_nx   = CW'(1);
                  state_nx = LOAD;
               end else if (w_loaded) begin
                  // A single-row batch goes straight to drain.
                  fwd_a    = 1'b1;
                  cnt_nx   = '0;
                  state_nx = i_last ? DRAIN : STREAM;
               end else begin
                  err = 1'b1;
               end
            end
         end
         LOAD: begin
            if (acc) begin
               if (i_is_b) begin
                  fwd_b = 1'b1;
                  if (cnt == LOAD_END) begin
                     w_loaded_nx = 1'b1;
                     cnt_nx      = '0;
                     state_nx    = STREAM;
                  end else begin
                     cnt_nx = cnt + CW'(1);
                  end
               end else begin
                  err = 1'b1;
               end
            end
         end
         STREAM: begin
            if (acc) begin
               if (!i_is_b) begin
                  fwd_a = 1'b1;
                  if (i_last) begin
                     cnt_nx   = '0;
                     state_nx = DRAIN;
                  end
               end else begin
                  err = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (cnt == DRAIN_END) begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
      endcase
   end

   // Lane k delays by 1+k; chains shift every cycle and load zeros
   // whenever no row is forwarded.
   for (genvar k = 0; k < SIZE; k++) begin : g_lane
      logic [k:0][WIDTH-1:0] d;
      logic [k:0]            v;
      logic [k:0]            c;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            d <= '0;
            v <= '0;
            c <= '0;
         end else begin
            d[0] <= (fwd_a | fwd_b) ? i_row[k] : '0;
            v[0] <= fwd_a | fwd_b;
            c[0] <= fwd_a;
            for (int j = 1; j <= k; j++) begin
               d[j] <= d[j-1];
               v[j] <= v[j-1];
               c[j] <= c[j-1];
            end
         end
      end

      assign o_a_rows[k] = d[k];
      assign o_a_vld[k]  = v[k];
      assign o_c_vld[k]  = c[k];
   end

`ifdef SA_FEEDER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_row_cnt <= '0;
      end else if (fwd_a) begin
         o_row_cnt <= o_row_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sa_feeder.sv
// tb_sa_feeder: directed self-checking bench for sa_feeder (SIZE=4).
// Scenarios: reset, drop in IDLE, load, stream, B in stream, mid reset.
module tb_sa_feeder;

   localparam int W = 16;
   localparam int S = 4;

   typedef logic [S-1:0][W-1:0] row_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_vld = 1'b0;
   logic          o_rdy;
   row_t          i_row = '0;
   logic          i_is_b = 1'b0;
   logic          i_last = 1'b0;
   logic          o_we;
   logic [S-1:0]  o_a_vld;
   row_t          o_a_rows;
   logic [S-1:0]  o_c_vld;
   logic          o_busy;
   logic          o_err;
`ifdef SA_FEEDER_STATS_EN
   logic [15:0]   o_row_cnt;
`endif

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   sa_feeder #(.WIDTH(W), .SIZE(S)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_vld    (i_vld),
      .o_rdy    (o_rdy),
      .i_row    (i_row),
      .i_is_b   (i_is_b),
      .i_last   (i_last),
      .o_we     (o_we),
      .o_a_vld  (o_a_vld),
      .o_a_rows (o_a_rows),
      .o_c_vld  (o_c_vld),
      .o_busy   (o_busy),
      .o_err    (o_err)
`ifdef SA_FEEDER_STATS_EN
      ,
      .o_row_cnt(o_row_cnt)
`endif
   );

   function automatic row_t mk(input int base);
      row_t r;
      for (int k = 0; k < S; k++) r[k] = W'(base + k);
      return r;
   endfunction

   task automatic step(input logic v, input logic b,
                       input logic l, input row_t r);
      i_vld  = v;
      i_is_b = b;
      i_last = l;
      i_row  = r;
      @(posedge clk);
      #1;
      i_vld  = 1'b0;
      i_is_b = 1'b0;
      i_last = 1'b0;
      i_row  = '0;
   endtask

   task automatic test_reset;
      #3;
      total++;
      if (o_we !== 1'b0) begin
         bad++;
         $display("FAIL rst_we got=%b exp=0", o_we);
      end
      total++;
      if (o_a_vld !== '0 || o_c_vld !== '0) begin
         bad++;
         $display("FAIL rst_vld got=%b/%b exp=0", o_a_vld, o_c_vld);
      end
      total++;
      if (o_a_rows !== '0) begin
         bad++;
         $display("FAIL rst_rows got=%h exp=0", o_a_rows);
      end
      total++;
      if (o_busy !== 1'b0 || o_err !== 1'b0) begin
         bad++;
         $display("FAIL rst_busy_err got=%b%b exp=00", o_busy, o_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (o_rdy !== 1'b1) begin
         bad++;
         $display("FAIL rst_rdy got=%b exp=1", o_rdy);
      end
   endtask

   task automatic test_idle_drop;
      step(1'b1, 1'b0, 1'b0, mk(7));
      total++;
      if (o_err !== 1'b1 || o_a_vld !== '0) begin
         bad++;
         $display("FAIL idle_drop got err=%b vld=%b exp err=1 vld=0",
                  o_err, o_a_vld);
      end
      for (int c = 0; c < S; c++) begin
         step(1'b0, 1'b0, 1'b0, '0);
         total++;
         if (o_err !== 1'b0 || o_a_vld !== '0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after c=%0d got err=%b vld=%b busy=%b",
                     c, o_err, o_a_vld, o_busy);
         end
      end
   endtask

   task automatic test_load;
      logic [S-1:0] ev;
      row_t         ed;
      for (int c = 0; c < 8; c++) begin
         int n;
         if (c < 4) step(1'b1, 1'b1, 1'b0, mk(100 + 10 * c));
         else step(1'b0, 1'b0, 1'b0, '0);
         n = c + 1;
         ev = '0;
         ed = '0;
         for (int k = 0; k < S; k++) begin
            int r;
            r = n - 1 - k;
            if (r >= 0 && r < 4) begin
               ev[k] = 1'b1;
               ed[k] = W'(100 + 10 * r + k);
            end
         end
         total++;
         if (o_we !== (n <= 4)) begin
            bad++;
            $display("FAIL load_we n=%0d got=%b exp=%b", n, o_we, n <= 4);
         end
         total++;
         if (o_a_vld !== ev || o_a_rows !== ed || o_c_vld !== '0) begin
            bad++;
            $display("FAIL load_lanes n=%0d got=%b %h %b exp=%b %h 0",
                     n, o_a_vld, o_a_rows, o_c_vld, ev, ed);
         end
         if (n == 4) begin
            total++;
            if (o_busy !== 1'b1 || o_rdy !== 1'b1) begin
               bad++;
               $display("FAIL load_stream got busy=%b rdy=%b exp=1 1",
                        o_busy, o_rdy);
            end
         end
      end
   endtask

   task automatic test_stream;
      logic [S-1:0] ev;
      row_t         ed;
      for (int c = 0; c < 6; c++) begin
         int n;
         if (c < 3) step(1'b1, 1'b0, c == 2, mk(10 * (c + 1)));
         else step(1'b0, 1'b0, 1'b0, '0);
         n = c + 1;
         ev = '0;
         ed = '0;
         for (int k = 0; k < S; k++) begin
            int idx;
            idx = n - 1 - k;
            if (idx >= 0 && idx < 3) begin
               ev[k] = 1'b1;
               ed[k] = W'(10 * (idx + 1) + k);
            end
         end
         total++;
         if (o_a_vld !== ev || o_a_rows !== ed || o_c_vld !== ev) begin
            bad++;
            $display("FAIL stream_lanes n=%0d got=%b %h %b exp=%b %h %b",
                     n, o_a_vld, o_a_rows, o_c_vld, ev, ed, ev);
         end
         total++;
         if (o_rdy !== !(n >= 3 && n <= 5) || o_busy !== (n <= 5)
             || o_we !== 1'b0) begin
            bad++;
            $display("FAIL stream_fsm n=%0d got rdy=%b busy=%b we=%b",
                     n, o_rdy, o_busy, o_we);
         end
      end
   endtask

   task automatic test_b_in_stream;
      step(1'b1, 1'b0, 1'b0, mk(50));
      total++;
      if (o_a_vld[0] !== 1'b1 || o_a_rows[0] !== W'(50)
          || o_err !== 1'b0 || o_busy !== 1'b1) begin
         bad++;
         $display("FAIL bis_first got vld=%b d=%0d err=%b busy=%b",
                  o_a_vld[0], o_a_rows[0], o_err, o_busy);
      end
      step(1'b1, 1'b1, 1'b0, mk(200));
      total++;
      if (o_err !== 1'b1 || o_we !== 1'b0 || o_a_vld[0] !== 1'b0
          || o_a_vld[1] !== 1'b1 || o_a_rows[1] !== W'(51)) begin
         bad++;
         $display("FAIL bis_err got err=%b we=%b vld=%b d1=%0d",
                  o_err, o_we, o_a_vld, o_a_rows[1]);
      end
      step(1'b1, 1'b0, 1'b1, mk(70));
      total++;
      if (o_err !== 1'b0 || o_a_vld[0] !== 1'b1 || o_c_vld[0] !== 1'b1
          || o_a_rows[0] !== W'(70) || o_rdy !== 1'b0) begin
         bad++;
         $display("FAIL bis_cont got err=%b vld=%b c=%b d0=%0d rdy=%b",
                  o_err, o_a_vld, o_c_vld, o_a_rows[0], o_rdy);
      end
      for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0, '0);
      total++;
      if (o_busy !== 1'b0 || o_a_vld !== 4'b1000
          || o_a_rows[3] !== W'(73)) begin
         bad++;
         $display("FAIL bis_end got busy=%b vld=%b d3=%0d exp 0 1000 73",
                  o_busy, o_a_vld, o_a_rows[3]);
      end
   endtask

   task automatic test_reset_mid;
      step(1'b1, 1'b0, 1'b0, mk(30));
      step(1'b1, 1'b0, 1'b0, mk(40));
      total++;
      if (o_a_vld !== 4'b0011 || o_busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_pre got vld=%b busy=%b exp 0011 1",
                  o_a_vld, o_busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (o_a_vld !== '0 || o_c_vld !== '0 || o_a_rows !== '0
          || o_we !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0) begin
         bad++;
         $display("FAIL mid_rst got vld=%b c=%b d=%h we=%b busy=%b err=%b",
                  o_a_vld, o_c_vld, o_a_rows, o_we, o_busy, o_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step(1'b0, 1'b0, 1'b0, '0);
         total++;
         if (o_a_vld !== '0 || o_a_rows !== '0 || o_c_vld !== '0) begin
            bad++;
            $display("FAIL mid_flush c=%0d got vld=%b d=%h",
                     c, o_a_vld, o_a_rows);
         end
      end
      step(1'b1, 1'b0, 1'b0, mk(60));
      total++;
      if (o_err !== 1'b1 || o_a_vld !== '0 || o_busy !== 1'b0) begin
         bad++;
         $display("FAIL mid_unloaded got err=%b vld=%b busy=%b",
                  o_err, o_a_vld, o_busy);
      end
   endtask

`ifdef SA_FEEDER_STATS_EN
   task automatic test_stats;
      total++;
      if (o_row_cnt !== 16'd0) begin
         bad++;
         $display("FAIL stats_rst got=%0d exp=0", o_row_cnt);
      end
      for (int c = 0; c < S; c++) step(1'b1, 1'b1, 1'b0, mk(c));
      for (int i = 0; i < 70000; i++)
         step(1'b1, 1'b0, i == 69999, mk(i));
      total++;
      if (o_row_cnt !== 16'd4464) begin
         bad++;
         $display("FAIL stats_wrap got=%0d exp=4464", o_row_cnt);
      end
      for (int c = 0; c < S; c++) step(1'b0, 1'b0, 1'b0, '0);
   endtask
`endif

   initial begin
      #5000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_idle_drop();
      test_load();
      test_stream();
      test_b_in_stream();
      test_reset_mid();
`ifdef SA_FEEDER_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
